// File: rtl/dmem_store_responder.sv
// dmem_store_responder
//   Word-addressed data RAM for the core's data port.  It also runs a sticky
//   pass/fail watch on the core's store stream, so a self-checking program
//   can report its result in hardware.
//
// Ports
//   clk          rising-edge clock
//   reset_n      asynchronous active-low reset
//   mem_write    store strobe from the core
//   data_adr     byte address for loads and stores
//   write_data   store data
//   read_data    combinational load data (0 for misaligned/out-of-range)
//   done         high once the watch FSM has left RUN
//   pass         high in PASS
//   fail_code    0 none, 1 illegal store, 2 misaligned/out-of-range, 3 timeout
//   store_count  stores seen while in RUN, saturating
//   last_adr     address of the most recent store (any state, legal or not)
//   last_data    data of the most recent store
//
// state | meaning
// RUN   | program running, stores and watchdog are being watched
// PASS  | completion store seen with the expected data (sticky)
// FAIL  | illegal store, bad address or watchdog expiry (sticky)
module dmem_store_responder #(
  parameter int          DEPTH        = 64,
  parameter logic [31:0] PASS_ADDR    = 32'd100,
  parameter logic [31:0] PASS_DATA    = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR = 32'd96,
  parameter int          TIMEOUT      = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        mem_write,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [15:0] store_count,
  output logic [31:0] last_adr,
  output logic [31:0] last_data
);

  localparam int AW  = $clog2(DEPTH);
  localparam int WDW = $clog2(TIMEOUT) + 1;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    PASS = 2'd1,
    FAIL = 2'd2
  } state_t;

  state_t           state, nextState;
  logic [1:0]       failCode, nextFailCode;
  logic [WDW-1:0]   watchdog;
  logic [31:0]      mem [DEPTH];

  logic             aligned, inRange, legalAdr;
  logic [AW-1:0]    wordIdx;

  assign aligned  = (data_adr[1:0] == 2'b00);
  assign inRange  = (data_adr < 32'(4 * DEPTH));
  assign legalAdr = aligned && inRange;
  assign wordIdx  = data_adr[AW+1:2];

  // Asynchronous read: a same-cycle write shows up only after the edge.
  assign read_data = legalAdr ? mem[wordIdx] : 32'h0;

  // RAM is deliberately not reset so its contents survive a mid-run reset.
  always_ff @(posedge clk) begin
    if (mem_write && legalAdr) begin
      mem[wordIdx] <= write_data;
    end
  end

  // Store outcomes take priority over the watchdog; a scratch store is the
  // only store that lets the timeout check fire in the same cycle.
  always_comb begin
    nextState    = state;
    nextFailCode = failCode;
    if (state == RUN) begin
      if (mem_write && !legalAdr) begin
        nextState    = FAIL;
        nextFailCode = 2'd2;
      end else if (mem_write && (data_adr == PASS_ADDR)) begin
        if (write_data == PASS_DATA) begin
          nextState = PASS;
        end else begin
          nextState    = FAIL;
          nextFailCode = 2'd1;
        end
      end else if (mem_write && (data_adr != SCRATCH_ADDR)) begin
        nextState    = FAIL;
        nextFailCode = 2'd1;
      end else if (watchdog == WDW'(TIMEOUT - 1)) begin
        nextState    = FAIL;
        nextFailCode = 2'd3;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RUN;
      failCode <= 2'd0;
    end else begin
      state    <= nextState;
      failCode <= nextFailCode;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      watchdog    <= '0;
      store_count <= 16'd0;
      last_adr    <= 32'd0;
      last_data   <= 32'd0;
    end else begin
      if (state == RUN) begin
        watchdog <= watchdog + WDW'(1);
        if (mem_write && (store_count != 16'hFFFF)) begin
          store_count <= store_count + 16'd1;
        end
      end
      if (mem_write) begin
        last_adr  <= data_adr;
        last_data <= write_data;
      end
    end
  end

  // Decoded straight from the state flops, so they change on the same edge
  // as the transition.
  assign done      = (state != RUN);
  assign pass      = (state == PASS);
  assign fail_code = failCode;

endmodule

// File: doc/dmem_store_responder.md
Name: dmem_store_responder

Overview:
- Data-memory responder for the core's data port: takes `mem_write`, `data_adr` and `write_data` from the core and returns `read_data`.
- Holds a word-addressed RAM and runs a sticky pass/fail watch FSM on the core's store stream.
- Adds a store counter, last-store capture and a cycle watchdog.
- Sits beside the core in the top level, so self-checking programs report pass or fail in hardware.

Parameters:
- DEPTH, 64, number of 32-bit words in RAM; power of two; AW = log2(DEPTH).
- PASS_ADDR, 32'd100, byte address of the completion store.
- PASS_DATA, 32'd25, data value required at PASS_ADDR for a pass.
- SCRATCH_ADDR, 32'd96, byte address where stores are allowed and do not finish the test.
- TIMEOUT, 1000, number of RUN cycles without a finishing store before the watchdog fails.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- mem_write  in  1  store strobe from the core.
- data_adr  in  32  byte address from the core, used for loads and stores.
- write_data  in  32  store data from the core.
- read_data  out  32  load data returned to the core.
- done  out  1  set once the FSM leaves RUN.
- pass  out  1  set in PASS state.
- fail_code  out  2  0 none, 1 illegal store, 2 misaligned/out-of-range, 3 timeout.
- store_count  out  16  accepted stores (see rules below).
- last_adr  out  32  address of the most recent store.
- last_data  out  32  data of the most recent store.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (clk, reset_n). When reset_n goes low, the block immediately sets:
  - state = RUN
  - done = 0, pass = 0, fail_code = 0
  - store_count = 0, last_adr = 0, last_data = 0
  - watchdog count = 0
  RAM contents are not reset and survive a mid-run reset.
- Decode:
  - aligned = (data_adr[1:0] == 0).
  - in_range = (data_adr < 4*DEPTH).
  - Word index = data_adr[AW+1:2].
- Read path: combinational. read_data = RAM[index] when aligned and in_range, else 32'h0. A read of the address being written in the same cycle returns the old value; the new value appears after the edge.
- Write path: on a rising edge with mem_write = 1, aligned and in_range, the RAM word is written. Writes happen in every state; a legal write still updates RAM in PASS/FAIL.
- last_adr/last_data: capture data_adr/write_data on every mem_write edge, in any state and whether legal or not.
- store_count: increments on each mem_write edge while in RUN and saturates at 16'hFFFF. It is frozen in PASS/FAIL.
- FSM states: RUN, PASS, FAIL. PASS and FAIL are sticky until reset. In RUN, on a rising edge, rules are checked in this priority order:
  1. mem_write and (!aligned or !in_range): go to FAIL, fail_code = 2. The RAM is not written.
  2. mem_write and data_adr == PASS_ADDR and write_data == PASS_DATA: go to PASS.
  3. mem_write and data_adr == PASS_ADDR with other data: go to FAIL, fail_code = 1.
  4. mem_write and data_adr != SCRATCH_ADDR: go to FAIL, fail_code = 1.
  5. mem_write and data_adr == SCRATCH_ADDR: stay in RUN.
  6. Watchdog == TIMEOUT-1 and none of rules 1-4 applies: go to FAIL, fail_code = 3.
- Store outcome versus timeout: a store outcome has priority over a timeout in the same cycle.
- Watchdog:
  - Increments every RUN cycle and holds in PASS/FAIL.
  - Width is clog2(TIMEOUT)+1 bits.
  - A SCRATCH store does not clear it.
- Output timing:
  - done = (state != RUN), pass = (state == PASS). Both are registered and go high on the same edge as the transition.
  - fail_code is registered, is non-zero only in FAIL, and is never changed once set.
- Unknown inputs: X on mem_write is not handled. The bench must drive 0/1 only.

Test Plan:
- Reset low for 22 ns, then high. Store 96←7, then 100←25. Required: after the second edge, pass = 1, done = 1, fail_code = 0, store_count = 2, last_adr = 100, last_data = 25.
- From RUN, store 100←24. Required: done = 1, pass = 0, fail_code = 1. A later store 100←25 leaves the state at FAIL and fail_code at 1.
- Store 104←25. Required: fail_code = 1. Then RAM[104] read returns 25, because the legal write still lands after the state has already changed.
- Store 98←5. Required: fail_code = 2, RAM unchanged. After reset, a store to 4*DEPTH = 256 also gives fail_code = 2, and read_data at 256 = 0.
- With TIMEOUT = 50 and no stores: FAIL with fail_code = 3 exactly on edge 50 after reset release. Rerun with store 100←25 on edge 50: pass = 1.
- Store 96←32'h1234. Required: read_data at 96 shows the old value before the edge and 32'h1234 after it. Then pull reset_n low mid-cycle. Required: done, pass and store_count clear without waiting for an edge, and read_data at 96 is still 32'h1234.
